// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: the in-flight entry
// record, the register-file forwarding code and source-field extraction.
package hazard_pkg;

    localparam int ADDR_W_MAX = 8;
    localparam int SRC_VEC_W  = 32;
    localparam int FWD_RF     = 0;

    typedef struct packed {
        logic                  valid;
        logic                  reg_write;
        logic                  mem_read;
        logic [ADDR_W_MAX-1:0] dst;
    } entry_t;

    localparam entry_t ENTRY_NONE = '0;

    // Extracts source s of width w from the packed address bus, zero-extended.
    function automatic logic [ADDR_W_MAX-1:0] src_slice(
        input logic [SRC_VEC_W-1:0] vec,
        input int                   s,
        input int                   w
    );
        logic [ADDR_W_MAX-1:0] mask;
        mask = ~({ADDR_W_MAX{1'b1}} << w);
        return ADDR_W_MAX'(vec >> (s * w)) & mask;
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Compares one ID source register against every tracked entry that can still
// be forwarded from and reports the youngest match and whether it is a load.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int FWD_W = 2
) (
    input  logic                  id_valid,
    input  logic                  src_used,
    input  logic [ADDR_W_MAX-1:0] src,
    input  entry_t [DEPTH-2:0]    entries,
    output logic                  hit,
    output logic                  load_hit,
    output logic [FWD_W-1:0]      youngest_k
);

    logic [DEPTH-2:0] match_s;
    logic [DEPTH-1:0] ld_chain_s;
    logic [FWD_W-1:0] k_chain_s [DEPTH];

    assign ld_chain_s[DEPTH-1] = 1'b0;
    assign k_chain_s[DEPTH-1]  = {FWD_W{1'b0}};

    // Priority chain runs from oldest to youngest so the lowest k wins.
    for (genvar k = 0; k < DEPTH - 1; k++) begin : g_cmp
        assign match_s[k] = id_valid & src_used & entries[k].valid & entries[k].reg_write
                          & (entries[k].dst != {ADDR_W_MAX{1'b0}}) & (entries[k].dst == src);
        assign ld_chain_s[k] = match_s[k] ? entries[k].mem_read : ld_chain_s[k+1];
        assign k_chain_s[k]  = match_s[k] ? FWD_W'(k) : k_chain_s[k+1];
    end

    assign hit        = |match_s;
    assign load_hit   = ld_chain_s[0];
    assign youngest_k = k_chain_s[0];

endmodule

// File: rtl/hazard_scoreboard.sv
// Load-use / RAW stall, forwarding select and branch flush controller that
// tracks in-flight destination registers for the stages after ID.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int   REG_ADDR_W = 5,
    parameter int   NUM_SRC    = 2,
    parameter int   DEPTH      = 3,
    parameter bit   FWD_EN     = 1'b1,
    parameter int   CNT_W      = 16,
    localparam int  FWD_W      = $clog2(DEPTH + 1)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          id_valid,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] id_src_addr,
    input  logic [NUM_SRC-1:0]            id_src_used,
    input  logic [REG_ADDR_W-1:0]         id_dst_addr,
    input  logic                          id_reg_write,
    input  logic                          id_mem_read,
    input  logic                          branch_taken,
    output logic                          stall,
    output logic                          flush,
    output logic [NUM_SRC*FWD_W-1:0]      fwd_sel,
    output logic [CNT_W-1:0]              stall_count,
    output logic [CNT_W-1:0]              flush_count
);

    // The WB slot never produces a hazard, so only the DEPTH-1 younger slots are stored.
    entry_t [DEPTH-2:0]         entries_r;
    entry_t [DEPTH-2:0]         next_s;
    entry_t                     head_s;
    logic [SRC_VEC_W-1:0]       src_vec_s;
    logic [NUM_SRC-1:0]         hit_s;
    logic [NUM_SRC-1:0]         load_hit_s;
    logic [NUM_SRC-1:0]         stall_req_s;
    logic [FWD_W-1:0]           young_k_s [NUM_SRC];
    logic [NUM_SRC*FWD_W-1:0]   fwd_next_s;
    logic [NUM_SRC*FWD_W-1:0]   fwd_sel_r;
    logic [CNT_W-1:0]           stall_count_r;
    logic [CNT_W-1:0]           flush_count_r;
    logic                       stall_s;
    logic                       flush_s;

    assign src_vec_s = SRC_VEC_W'(id_src_addr);

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        hazard_match #(
            .DEPTH (DEPTH),
            .FWD_W (FWD_W)
        ) u_match (
            .id_valid   (id_valid),
            .src_used   (id_src_used[s]),
            .src        (src_slice(src_vec_s, s, REG_ADDR_W)),
            .entries    (entries_r),
            .hit        (hit_s[s]),
            .load_hit   (load_hit_s[s]),
            .youngest_k (young_k_s[s])
        );

        // A load can only be forwarded once it has left EX.
        assign stall_req_s[s] = FWD_EN ? (load_hit_s[s] & (young_k_s[s] == {FWD_W{1'b0}}))
                                       : hit_s[s];
        assign fwd_next_s[s*FWD_W +: FWD_W] = (FWD_EN && hit_s[s]) ? young_k_s[s] + FWD_W'(1)
                                                                  : FWD_W'(FWD_RF);
    end

    assign flush_s = reset & branch_taken;
    assign stall_s = reset & ~branch_taken & (|stall_req_s);

    // A stalled or flushed ID instruction enters EX as a bubble.
    assign head_s    = {id_valid & ~stall_s & ~flush_s, id_reg_write, id_mem_read,
                        ADDR_W_MAX'(id_dst_addr)};
    assign next_s[0] = head_s;

    for (genvar k = 1; k < DEPTH - 1; k++) begin : g_shift
        if (k == 1) begin : g_mem
            assign next_s[k] = flush_s ? ENTRY_NONE : entries_r[k-1];
        end else begin : g_older
            assign next_s[k] = entries_r[k-1];
        end
    end

    // In-flight destination tracking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            entries_r <= {(DEPTH-1){ENTRY_NONE}};
        end else begin
            entries_r <= next_s;
        end
    end

    // Forwarding select for the instruction that moves into EX.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fwd_sel_r <= {(NUM_SRC*FWD_W){1'b0}};
        end else if (stall_s || flush_s) begin
            fwd_sel_r <= {(NUM_SRC*FWD_W){1'b0}};
        end else begin
            fwd_sel_r <= fwd_next_s;
        end
    end

    // Saturating stall counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_count_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    // Saturating flush counter.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flush_count_r <= {CNT_W{1'b0}};
        end else if (flush_s && (flush_count_r != {CNT_W{1'b1}})) begin
            flush_count_r <= flush_count_r + CNT_W'(1);
        end else begin
            flush_count_r <= flush_count_r;
        end
    end

    assign stall       = stall_s;
    assign flush       = flush_s;
    assign fwd_sel     = fwd_sel_r;
    assign stall_count = stall_count_r;
    assign flush_count = flush_count_r;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a forwarding instance and a stall-only instance
// with narrow counters share one stimulus stream and are checked against a model.
module tb_hazard_scoreboard;

    localparam int DEPTH = 3;

    logic       clk;
    logic       reset;
    logic       id_valid;
    logic [9:0] id_src_addr;
    logic [1:0] id_src_used;
    logic [4:0] id_dst_addr;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       branch_taken;

    logic        stall_a, flush_a;
    logic [3:0]  fwd_a;
    logic [15:0] sc_a, fc_a;
    logic        stall_b, flush_b;
    logic [3:0]  fwd_b;
    logic [1:0]  sc_b, fc_b;

    hazard_scoreboard dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .branch_taken(branch_taken), .stall(stall_a),
        .flush(flush_a), .fwd_sel(fwd_a), .stall_count(sc_a), .flush_count(fc_a)
    );

    hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(2)) dut_so (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_src_used(id_src_used), .id_dst_addr(id_dst_addr), .id_reg_write(id_reg_write),
        .id_mem_read(id_mem_read), .branch_taken(branch_taken), .stall(stall_b),
        .flush(flush_b), .fwd_sel(fwd_b), .stall_count(sc_b), .flush_count(fc_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: each producer is remembered with the cycle it entered EX; its stage is the age.
    typedef struct {
        int         m;
        int         ex_cyc;
        bit         ld;
        logic [4:0] dst;
    } rec_t;

    rec_t       q[$];
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         known = 1'b0;
    bit         e_stall [2];
    bit         e_flush [2];
    logic [3:0] e_fwd [2];
    logic [3:0] n_fwd [2];
    int         e_sc [2];
    int         e_fc [2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int young(input int m, input logic [4:0] src, output bit ld);
        int best;
        best = -1;
        ld = 1'b0;
        foreach (q[i]) begin
            int st;
            st = cyc - q[i].ex_cyc;
            if (q[i].m == m && src != 5'd0 && q[i].dst == src && st >= 0 && st <= DEPTH - 2
                && (best < 0 || st < best)) begin
                best = st;
                ld = q[i].ld;
            end
        end
        return best;
    endfunction

    task automatic step();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            bit         raw;
            bit         ld;
            int         st;
            logic [1:0] sel [2];
            logic [4:0] src;
            raw = 1'b0;
            for (int s = 0; s < 2; s++) begin
                src = id_src_addr[s*5 +: 5];
                ld = 1'b0;
                st = -1;
                if (id_valid && id_src_used[s]) st = young(m, src, ld);
                if (m == 0) begin
                    if (st == 0 && ld) raw = 1'b1;
                    sel[s] = (st >= 0) ? 2'(st + 1) : 2'd0;
                end else begin
                    if (st >= 0) raw = 1'b1;
                    sel[s] = 2'd0;
                end
            end
            e_flush[m] = reset && branch_taken;
            e_stall[m] = reset && !branch_taken && raw;
            n_fwd[m] = (e_stall[m] || e_flush[m]) ? 4'd0 : {sel[1], sel[0]};
        end
        check("stall_fwd", {31'd0, stall_a}, {31'd0, e_stall[0]});
        check("flush_fwd", {31'd0, flush_a}, {31'd0, e_flush[0]});
        check("stall_so",  {31'd0, stall_b}, {31'd0, e_stall[1]});
        check("flush_so",  {31'd0, flush_b}, {31'd0, e_flush[1]});
        if (known) begin
            check("fwd_sel_fwd", {28'd0, fwd_a}, {28'd0, e_fwd[0]});
            check("fwd_sel_so",  {28'd0, fwd_b}, {28'd0, e_fwd[1]});
            check("stall_cnt_fwd", {16'd0, sc_a}, e_sc[0]);
            check("flush_cnt_fwd", {16'd0, fc_a}, e_fc[0]);
            check("stall_cnt_so",  {30'd0, sc_b}, e_sc[1]);
            check("flush_cnt_so",  {30'd0, fc_b}, e_fc[1]);
        end
        @(posedge clk);
        if (!reset) begin
            q.delete();
            for (int m = 0; m < 2; m++) begin
                e_fwd[m] = 4'd0;
                e_sc[m] = 0;
                e_fc[m] = 0;
            end
            known = 1'b1;
        end else begin
            for (int m = 0; m < 2; m++) begin
                int sat;
                sat = (m == 0) ? 65535 : 3;
                if (e_flush[m]) begin
                    for (int i = q.size() - 1; i >= 0; i--)
                        if (q[i].m == m && q[i].ex_cyc == cyc) q.delete(i);
                end else if (!e_stall[m] && id_valid && id_reg_write && id_dst_addr != 5'd0) begin
                    q.push_back('{m, cyc + 1, id_mem_read, id_dst_addr});
                end
                if (e_stall[m] && e_sc[m] < sat) e_sc[m]++;
                if (e_flush[m] && e_fc[m] < sat) e_fc[m]++;
                e_fwd[m] = n_fwd[m];
            end
        end
        cyc++;
        for (int i = q.size() - 1; i >= 0; i--)
            if (cyc - q[i].ex_cyc >= DEPTH) q.delete(i);
        #1;
    endtask

    task automatic set_id(input bit v, input int s0, input int s1, input logic [1:0] used,
                          input int dst, input bit rw, input bit ld, input bit br);
        id_valid     = v;
        id_src_addr  = {5'(s1), 5'(s0)};
        id_src_used  = used;
        id_dst_addr  = 5'(dst);
        id_reg_write = rw;
        id_mem_read  = ld;
        branch_taken = br;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        set_id(1'b0, 0, 0, 2'b00, 0, 1'b0, 1'b0, 1'b0);
        step();
        step();
        check("rst_fwd_sel", {28'd0, fwd_a}, 32'd0);
        check("rst_stall_cnt", {16'd0, sc_a}, 32'd0);
        check("rst_flush_cnt", {16'd0, fc_a}, 32'd0);
        reset = 1'b1;
        step();

        // add r3 ; sub r4,r3,r5 forwards from EX/MEM
        set_id(1'b1, 1, 2, 2'b11, 3, 1'b1, 1'b0, 1'b0); step();
        set_id(1'b1, 3, 5, 2'b11, 4, 1'b1, 1'b0, 1'b0); step();
        check("addsub_fwd_sel", {28'd0, fwd_a}, 32'h1);
        check("addsub_no_stall", {16'd0, sc_a}, 32'd0);

        // lw r3 ; add r4,r3,r3 held through the one-cycle bubble
        do_reset();
        set_id(1'b1, 1, 0, 2'b01, 3, 1'b1, 1'b1, 1'b0); step();
        set_id(1'b1, 3, 3, 2'b11, 4, 1'b1, 1'b0, 1'b0); step(); step();
        check("loaduse_fwd_sel", {28'd0, fwd_a}, 32'ha);
        check("loaduse_stall_cnt", {16'd0, sc_a}, 32'd1);

        // taken branch overrides a pending load-use stall
        do_reset();
        set_id(1'b1, 1, 0, 2'b01, 3, 1'b1, 1'b1, 1'b0); step();
        set_id(1'b1, 3, 0, 2'b01, 4, 1'b1, 1'b0, 1'b1); step();
        check("branch_flush_cnt", {16'd0, fc_a}, 32'd1);
        check("branch_stall_cnt", {16'd0, sc_a}, 32'd0);
        set_id(1'b1, 3, 0, 2'b01, 4, 1'b1, 1'b0, 1'b0); step();
        check("branch_killed_load", {16'd0, sc_a}, 32'd0);
        branch_taken = 1'b1; step(); step();
        check("branch_twice_cnt", {16'd0, fc_a}, 32'd3);

        // r0 never creates a dependence
        do_reset();
        set_id(1'b1, 1, 2, 2'b11, 0, 1'b1, 1'b0, 1'b0); step();
        set_id(1'b1, 0, 0, 2'b11, 4, 1'b1, 1'b0, 1'b0); step();
        check("r0_fwd_sel", {28'd0, fwd_a}, 32'd0);
        check("r0_stall_so", {30'd0, sc_b}, 32'd0);

        // stall-only: dependence on EX stalls DEPTH-1 cycles, then counter saturates
        do_reset();
        set_id(1'b1, 1, 2, 2'b11, 3, 1'b1, 1'b0, 1'b0); step();
        set_id(1'b1, 3, 0, 2'b01, 4, 1'b1, 1'b0, 1'b0); step(); step(); step();
        check("so_stall_cnt", {30'd0, sc_b}, 32'd2);
        check("so_fwd_sel", {28'd0, fwd_b}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            set_id(1'b1, 1, 2, 2'b11, 6 + i, 1'b1, 1'b0, 1'b0); step();
            set_id(1'b1, 6 + i, 0, 2'b01, 9, 1'b1, 1'b0, 1'b0); step(); step(); step();
        end
        check("so_stall_cnt_sat", {30'd0, sc_b}, 32'd3);

        // random traffic on a small register window to provoke hazards
        for (int n = 0; n < 400; n++) begin
            reset = ($urandom_range(49) != 0);
            set_id($urandom_range(7) != 0, $urandom_range(3), $urandom_range(3),
                   2'($urandom_range(3)), $urandom_range(3), $urandom_range(3) != 0,
                   $urandom_range(2) == 0, $urandom_range(9) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
